// File: rtl/render_pixel_scanner.sv
// render_pixel_scanner: walks the render frame in raster order, issues each
// coordinate to the shader, and pairs in-order shader responses with their
// coordinates to feed the framebuffer writer.
module render_pixel_scanner #(
    parameter int WIDTH           = 512,
    parameter int HEIGHT          = 384,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    output logic        req_valid_out,
    input  logic        req_ready_in,
    output logic [10:0] req_x_out,
    output logic [9:0]  req_y_out,
    input  logic        resp_valid_in,
    input  logic [3:0]  resp_r_in,
    input  logic [3:0]  resp_g_in,
    input  logic [3:0]  resp_b_in,
    input  logic        resp_visible_in,
    output logic [10:0] x_out_block,
    output logic [9:0]  y_out_block,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic        block_visible_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        error_out
);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = AW + 1;
    localparam logic [10:0]   X_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]    Y_LAST = 10'(HEIGHT - 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic [CW-1:0] r_outst;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [20:0]   r_tag [MAX_OUTSTANDING];
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_valid;
    logic [10:0]   r_ox;
    logic [9:0]    r_oy;
    logic [3:0]    r_r, r_g, r_b;
    logic          r_vis;

    logic w_xfer;
    logic w_resp_ok;

    // Request valid depends only on registered state, so a response can never
    // combinationally open a slot for a same-cycle transfer.
    assign req_valid_out = (r_state == S_ISSUE) && (r_outst < MAX_C);
    assign req_x_out     = r_x;
    assign req_y_out     = r_y;
    assign w_xfer        = req_valid_out && req_ready_in;
    assign w_resp_ok     = resp_valid_in && (r_outst != '0);

    assign x_out_block       = r_ox;
    assign y_out_block       = r_oy;
    assign r_out             = r_r;
    assign g_out             = r_g;
    assign b_out             = r_b;
    assign block_visible_out = r_vis;
    assign valid_out         = r_valid;
    assign busy_out          = r_busy;
    assign frame_done_out    = r_done;
    assign error_out         = r_err;

    // Frame-pass FSM: raster walk of the issue coordinate, drain, done pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_state <= S_ISSUE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_xfer) begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            if (r_y == Y_LAST) begin
                                r_y     <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // outst==0 here means the final pixel strobes this cycle.
                    if (r_outst == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding count and tag FIFO pointers; occupancy equals r_outst.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_outst <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            case ({w_xfer, w_resp_ok})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            if (w_xfer)    r_wr <= r_wr + 1'b1;
            if (w_resp_ok) r_rd <= r_rd + 1'b1;
        end
    end

    // Tag storage: coordinate of each accepted request, {y, x}.
    always_ff @(posedge clk_in) begin
        if (w_xfer) r_tag[r_wr] <= {r_y, r_x};
    end

    // Registered pixel output and sticky error on unmatched responses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_vis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_resp_ok;
            if (w_resp_ok) begin
                {r_oy, r_ox} <= r_tag[r_rd];
                r_r          <= resp_r_in;
                r_g          <= resp_g_in;
                r_b          <= resp_b_in;
                r_vis        <= resp_visible_in;
            end
            if (resp_valid_in && (r_outst == '0)) r_err <= 1'b1;
        end
    end
endmodule
